// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes queue in a circular FIFO and go out LSB-first, frames back-to-back.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   tx_busy,
  output logic                   tx_irq,
  output logic                   uart_tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int TW  = $clog2(DIV);

  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic [7:0]    shift;

  logic push;
  logic pop;
  logic bit_end;

  assign bit_end = (timer == T_LAST);
  assign push    = tx_valid && (level < FULL);
  assign pop     = (level != '0) &&
                   ((state == S_IDLE) ||
                    ((state == S_STOP) && bit_end));

  assign tx_ready   = (level < FULL);
  assign fifo_level = level;
  assign tx_busy    = (state != S_IDLE);
  assign tx_irq     = (state == S_STOP) && bit_end;

  // FIFO storage; contents need no reset, the level gates every read
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Pointers wrap modulo DEPTH; level tracks occupancy 0..DEPTH
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame sequencer; the line is registered so it never glitches
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      idx     <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          timer   <= '0;
          uart_tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            state   <= S_START;
            uart_tx <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            timer   <= '0;
            idx     <= '0;
            state   <= S_DATA;
            uart_tx <= shift[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer <= '0;
            shift <= {1'b0, shift[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              uart_tx <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              state   <= S_START;
              uart_tx <= 1'b0;
            end else begin
              state   <= S_IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
